// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants, counter width and lock-FSM encoding for the VGA monitor.
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam bit          VGA_SYNC_POL = 1'b1;

  localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Wide enough to see a line with a dropped hsync (2 * H_TOTAL) without wrapping.
  localparam int unsigned CNT_W = 12;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } mon_state_e;

endpackage

// File: rtl/vga_monitor_if.sv
// Stream and status bundle between a VGA source/bench (master) and vga_monitor (slave).
// blank_err is present only when VGA_MON_BLANK_CHECK_EN is defined.
interface vga_monitor_if;

  logic        p_tick;
  logic        hsync;
  logic        vsync;
  logic [7:0]  rgb;
  logic [9:0]  cap_x;
  logic [9:0]  cap_y;
  logic        locked;
  logic [7:0]  cap_rgb;
  logic        cap_valid;
  logic [31:0] frame_sum;
  logic        sum_valid;
  logic [7:0]  err_count;
`ifdef VGA_MON_BLANK_CHECK_EN
  logic        blank_err;
`endif

  modport master (
    output p_tick, hsync, vsync, rgb, cap_x, cap_y,
`ifdef VGA_MON_BLANK_CHECK_EN
    input  blank_err,
`endif
    input  locked, cap_rgb, cap_valid, frame_sum, sum_valid, err_count
  );

  modport slave (
    input  p_tick, hsync, vsync, rgb, cap_x, cap_y,
`ifdef VGA_MON_BLANK_CHECK_EN
    output blank_err,
`endif
    output locked, cap_rgb, cap_valid, frame_sum, sum_valid, err_count
  );

endinterface

// File: rtl/vga_monitor_axis.sv
// One timing axis: sync leading-edge detector, period counter and period compare.
// cnt_o is the position of the sample currently presented (the counter's next value).
module vga_mon_axis
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL       = VGA_H_TOTAL,
  parameter bit          POL         = VGA_SYNC_POL,
  // 0: the edge sample is position 0 (horizontal). 1: an increment on the edge counts (vertical).
  parameter bit          EDGE_COUNTS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             sync_i,
  input  logic             inc_i,
  input  logic             disarm_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             edge_o,
  output logic             mismatch_o
);

  logic             sync_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   per;

  assign edge_o = tick_i && (sync_i == POL) && (sync_q != POL);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_o)
      cnt_d = (EDGE_COUNTS && inc_i) ? CNT_W'(1) : '0;
    else if (tick_i && inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  assign per        = EDGE_COUNTS ? {1'b0, cnt_q} : ({1'b0, cnt_q} + 1'b1);
  // The first edge after reset (or after a disarm) only starts a measurement.
  assign mismatch_o = edge_o && armed_q && (per != (CNT_W + 1)'(TOTAL));
  assign cnt_o      = cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (tick_i) begin
      sync_q <= sync_i;
      cnt_q  <= cnt_d;
      if (edge_o)
        armed_q <= 1'b1;
      else if (disarm_i)
        armed_q <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_monitor.sv
// Receive-side VGA timing/lock checker with single-pixel capture and per-frame rgb checksum.
// Optional blank-region rgb check enabled by defining VGA_MON_BLANK_CHECK_EN.
module vga_monitor
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          SYNC_POL = VGA_SYNC_POL
) (
  input logic          clk,
  input logic          reset,
  vga_monitor_if.slave mon
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned V_START = V_SYNC + V_BP;

  logic [CNT_W-1:0] hcnt, vcnt, x, y;
  logic             h_edge, v_edge, h_mis, v_mis, mismatch;
  logic             active, capture;

  mon_state_e  state_q, state_d;
  logic        clean_q, clean_d;
  logic        frame_ok_q;
  logic [7:0]  err_q;
  logic [9:0]  capx_q, capy_q;
  logic [7:0]  cap_rgb_q;
  logic        cap_valid_q;
  logic [31:0] acc_q, sum_q;
  logic        sum_valid_q;

  vga_mon_axis #(.TOTAL(H_TOTAL), .POL(SYNC_POL), .EDGE_COUNTS(1'b0)) u_h_axis (
    .clk        (clk),
    .reset      (reset),
    .tick_i     (mon.p_tick),
    .sync_i     (mon.hsync),
    .inc_i      (1'b1),
    .disarm_i   (1'b0),
    .cnt_o      (hcnt),
    .edge_o     (h_edge),
    .mismatch_o (h_mis)
  );

  // A horizontal error corrupts this frame's line count, so the vertical check re-arms.
  vga_mon_axis #(.TOTAL(V_TOTAL), .POL(SYNC_POL), .EDGE_COUNTS(1'b1)) u_v_axis (
    .clk        (clk),
    .reset      (reset),
    .tick_i     (mon.p_tick),
    .sync_i     (mon.vsync),
    .inc_i      (h_edge),
    .disarm_i   (h_mis),
    .cnt_o      (vcnt),
    .edge_o     (v_edge),
    .mismatch_o (v_mis)
  );

  assign mismatch = h_mis || v_mis;
  assign x        = hcnt - CNT_W'(H_START);
  assign y        = vcnt - CNT_W'(V_START);
  assign active   = (hcnt >= CNT_W'(H_START)) && (hcnt < CNT_W'(H_START + H_ACTIVE)) &&
                    (vcnt >= CNT_W'(V_START)) && (vcnt < CNT_W'(V_START + V_ACTIVE));
  assign capture  = mon.p_tick && active && (state_q == ST_LOCKED) &&
                    (x == CNT_W'(capx_q)) && (y == CNT_W'(capy_q));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    clean_d = clean_q;
    if (mismatch) begin
      state_d = ST_SEARCH;
      clean_d = 1'b0;
    end else if (v_edge) begin
      case (state_q)
        ST_SEARCH: begin
          state_d = ST_MEASURE;
          clean_d = 1'b0;
        end
        ST_MEASURE: begin
          if (clean_q) state_d = ST_LOCKED;
          else         clean_d = 1'b1;
        end
        ST_LOCKED: ;
        default:   state_d = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      clean_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      err_q       <= '0;
      capx_q      <= '0;
      capy_q      <= '0;
      cap_rgb_q   <= '0;
      cap_valid_q <= 1'b0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clean_q     <= clean_d;
      cap_valid_q <= 1'b0;
      sum_valid_q <= 1'b0;
      if (mismatch && (err_q != 8'hFF))
        err_q <= err_q + 1'b1;
      if (v_edge) begin
        capx_q      <= mon.cap_x;
        capy_q      <= mon.cap_y;
        sum_q       <= acc_q;
        acc_q       <= '0;
        sum_valid_q <= frame_ok_q && !mismatch;
        frame_ok_q  <= (state_d == ST_LOCKED);
      end else begin
        if (mon.p_tick && active)
          acc_q <= acc_q + 32'(mon.rgb);
        if (state_q != ST_LOCKED)
          frame_ok_q <= 1'b0;
      end
      if (capture) begin
        cap_rgb_q   <= mon.rgb;
        cap_valid_q <= 1'b1;
      end
    end
  end

`ifdef VGA_MON_BLANK_CHECK_EN
  logic blank_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      blank_err_q <= 1'b0;
    else if (mon.p_tick && !active && (state_q == ST_LOCKED) && (mon.rgb != 8'h00))
      blank_err_q <= 1'b1;
  end

  assign mon.blank_err = blank_err_q;
`endif

  assign mon.locked    = (state_q == ST_LOCKED);
  assign mon.cap_rgb   = cap_rgb_q;
  assign mon.cap_valid = cap_valid_q;
  assign mon.frame_sum = sum_q;
  assign mon.sum_valid = sum_valid_q;
  assign mon.err_count = err_q;

endmodule

// File: tb/tb_vga_monitor.sv
// Directed bench for vga_monitor on a reduced 25x13 raster so many frames fit in a short run.
// Frames start with coincident hsync/vsync leading edges; line l therefore sits at vcnt = l+1.
module tb_vga_monitor;

  localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VSY = 2, VB = 2;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int HSTART = HSY + HB;
  localparam int VSTART = VSY + VB;

  localparam int MODE_ONE   = 0;
  localparam int MODE_XY    = 1;
  localparam int MODE_BLANK = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_cap = 0;
  int   n_sum = 0;
  int   last_sum;

  vga_monitor_if bus ();

  vga_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SYNC_POL(1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.cap_valid) n_cap <= n_cap + 1;
    if (bus.sum_valid) n_sum <= n_sum + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int mode, input int px, input int py);
    logic [31:0] xv, yv;
    xv = px;
    yv = py;
    return (mode == MODE_ONE) ? 8'h01 : (xv[7:0] ^ yv[7:0]);
  endfunction

  task automatic pix(input logic hs, input logic vs, input logic [7:0] d);
    @(negedge clk);
    bus.p_tick = 1'b1;
    bus.hsync  = hs;
    bus.vsync  = vs;
    bus.rgb    = d;
    @(negedge clk);
    bus.p_tick = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(bus.locked), 0);
    check({tag, "_cap_rgb"}, 32'(bus.cap_rgb), 0);
    check({tag, "_cap_valid"}, 32'(bus.cap_valid), 0);
    check({tag, "_frame_sum"}, bus.frame_sum, 0);
    check({tag, "_sum_valid"}, 32'(bus.sum_valid), 0);
    check({tag, "_err_count"}, 32'(bus.err_count), 0);
`ifdef VGA_MON_BLANK_CHECK_EN
    check({tag, "_blank_err"}, 32'(bus.blank_err), 0);
`endif
  endtask

  // One full frame; checks at its first tick cover the vsync edge that closed the previous frame.
  task automatic frame(input int mode, input int drop_line, input int rst_line,
                       input int exp_lock, input int exp_sv, input int exp_sum,
                       output int sum_out);
    int xx, yy, acc;
    bit act;
    logic hs, vs;
    logic [7:0] d;
    acc = 0;
    for (int l = 0; l < VT; l++) begin
      for (int hc = 0; hc < HT; hc++) begin
        hs  = (hc < HSY) && (l != drop_line);
        vs  = (l < VSY);
        xx  = hc - HSTART;
        yy  = l + 1 - VSTART;
        act = (xx >= 0) && (xx < HA) && (yy >= 0) && (yy < VA);
        d   = act ? pix_val(mode, xx, yy) : 8'h00;
        if (mode == MODE_BLANK && l == 0 && hc == 10) d = 8'hFF;
        if (act) acc += int'(d);
        pix(hs, vs, d);
        if (l == 0 && hc == 0) begin
          if (exp_lock >= 0) check("locked_at_vsync", 32'(bus.locked), exp_lock);
          if (exp_sv >= 0)   check("sum_valid_at_vsync", 32'(bus.sum_valid), exp_sv);
          if (exp_sv == 1)   check("frame_sum", bus.frame_sum, exp_sum);
        end
        if (drop_line >= 0 && hc == 0 && l == drop_line)
          check("locked_before_drop", 32'(bus.locked), 1);
        if (drop_line >= 0 && hc == 0 && l == drop_line + 1)
          check("locked_after_drop", 32'(bus.locked), 0);
        if (l == rst_line && hc == 12) begin
          reset = 1'b1;
          #1;
          check_all_zero("midline_reset");
          reset = 1'b0;
        end
      end
    end
    sum_out = acc;
  endtask

  initial begin
    reset      = 1'b1;
    bus.p_tick = 1'b0;
    bus.hsync  = 1'b0;
    bus.vsync  = 1'b0;
    bus.rgb    = 8'h00;
    bus.cap_x  = 10'd700;
    bus.cap_y  = 10'd0;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("after_reset");

    // Lock acquisition on constant rgb; out-of-range capture column never fires.
    frame(MODE_ONE, -1, -1, 0, -1, 0, last_sum);
    frame(MODE_ONE, -1, -1, 0, 0, 0, last_sum);
    frame(MODE_ONE, -1, -1, 1, 0, 0, last_sum);
    frame(MODE_ONE, -1, -1, 1, 1, last_sum, last_sum);
    frame(MODE_ONE, -1, -1, 1, 1, last_sum, last_sum);
    check("sum_pulses_after_lock", n_sum, 2);
    check("no_cap_out_of_range", n_cap, 0);

    // Capture first and last active pixel of an x^y pattern.
    bus.cap_x = 10'd0;
    bus.cap_y = 10'd0;
    frame(MODE_XY, -1, -1, 1, 1, last_sum, last_sum);
    check("cap_count_origin", n_cap, 1);
    check("cap_rgb_origin", 32'(bus.cap_rgb), 32'(pix_val(MODE_XY, 0, 0)));
    bus.cap_x = 10'(HA - 1);
    bus.cap_y = 10'(VA - 1);
    frame(MODE_XY, -1, -1, 1, 1, last_sum, last_sum);
    check("cap_count_corner", n_cap, 2);
    check("cap_rgb_corner", 32'(bus.cap_rgb), 32'(pix_val(MODE_XY, HA - 1, VA - 1)));

    // Dropped hsync pulse: one error, lock lost, relock after two clean frames.
    frame(MODE_XY, 6, -1, 1, 1, last_sum, last_sum);
    check("err_after_drop", 32'(bus.err_count), 1);
    check("locked_end_bad_frame", 32'(bus.locked), 0);
    frame(MODE_XY, -1, -1, 0, 0, 0, last_sum);
    check("err_no_vertical_error", 32'(bus.err_count), 1);
    frame(MODE_XY, -1, -1, 0, 0, 0, last_sum);
    frame(MODE_XY, -1, -1, 1, 0, 0, last_sum);
    frame(MODE_XY, -1, -1, 1, 1, last_sum, last_sum);

    // Reset mid-line while locked, then relock.
    frame(MODE_XY, -1, 5, 1, 1, last_sum, last_sum);
    frame(MODE_XY, -1, -1, 0, 0, 0, last_sum);
    frame(MODE_XY, -1, -1, 0, 0, 0, last_sum);
    frame(MODE_XY, -1, -1, 1, 0, 0, last_sum);
    frame(MODE_XY, -1, -1, 1, 1, last_sum, last_sum);
    check("err_after_relock", 32'(bus.err_count), 0);

`ifdef VGA_MON_BLANK_CHECK_EN
    check("blank_err_clean", 32'(bus.blank_err), 0);
    frame(MODE_BLANK, -1, -1, 1, 1, last_sum, last_sum);
    check("blank_err_set", 32'(bus.blank_err), 1);
    frame(MODE_XY, -1, -1, 1, 1, last_sum, last_sum);
    check("blank_err_sticky", 32'(bus.blank_err), 1);
    reset = 1'b1;
    #1;
    check("blank_err_reset", 32'(bus.blank_err), 0);
    @(negedge clk);
    reset = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
